mult_div_unit: RTL and testbench

Multiply/divide unit for the Execute stage of the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the E-stage controller, using the already-forwarded rs/rt operands. It models multi-cycle latency with a countdown and drives `busy` so that hazard logic can freeze the D stage. It owns the architectural HI/LO registers, which MFHI/MFLO read directly.

---
 rtl/md_pkg.sv | 23 ++
 rtl/md_arith.sv | 53 +++++
 rtl/mult_div_unit.sv | 99 +++++++++
 tb/tb_mult_div_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared op encoding, default latencies and FSM state encoding for the multiply/divide unit.
// Latency: none (constants and types only).
// Backpressure: none; the E-stage controller imports the same op constants.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;
    localparam logic [2:0] MD_RSVD  = 3'd7;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

endpackage

// File: rtl/md_arith.sv
// Combinational product/quotient generator: (op, a, b) -> {res_hi, res_lo}, div_zero.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the result.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic        signed_div;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] safe_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_u = {32'd0, a} * {32'd0, b};
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Signed divide runs on magnitudes so 0x80000000 / -1 needs no overflow special case:
    // |0x80000000| is 2^31 as an unsigned value and negates back to itself.
    assign signed_div = (op == MD_DIV);
    assign mag_a      = (signed_div && a[31]) ? (~a + 32'd1) : a;
    assign mag_b      = (signed_div && b[31]) ? (~b + 32'd1) : b;
    assign div_zero   = ((op == MD_DIV) || (op == MD_DIVU)) && (b == 32'd0);
    assign safe_b     = (b == 32'd0) ? 32'd1 : mag_b;
    assign q_mag      = mag_a / safe_b;
    assign r_mag      = mag_a % safe_b;
    assign quot       = (signed_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem        = (signed_div && a[31]) ? (~r_mag + 32'd1) : r_mag;

    // Select the HI/LO pair for the requested operation.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:         {res_hi, res_lo} = prod_s;
            MD_MULTU:        {res_hi, res_lo} = prod_u;
            MD_DIV, MD_DIVU: {res_hi, res_lo} = {rem, quot};
            default:         {res_hi, res_lo} = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT* commit after MULT_CYCLES, DIV* after DIV_CYCLES; MTHI/MTLO write at the accept edge.
// Backpressure: busy is high while an op is in flight; start during RUN is dropped, so upstream must stall.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q;
    logic [31:0]        lo_q;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               div_zero;
    logic               accept;
    logic               is_mult;
    logic               is_div;

    md_arith u_arith (
        .op       (op),
        .a        (src_a),
        .b        (src_b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign accept  = start && (state == ST_IDLE) && (op != MD_NONE) && (op != MD_RSVD);
    assign is_mult = (op == MD_MULT) || (op == MD_MULTU);
    assign is_div  = (op == MD_DIV)  || (op == MD_DIVU);

    assign hi_out = hi_q;
    assign lo_out = lo_q;

    // FSM: accept in IDLE, count down in RUN, commit pending HI/LO when the counter hits zero.
    // A divide by zero latches the current HI/LO as pending so the commit leaves them unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mult || is_div) begin
                            pend_hi <= div_zero ? hi_q : res_hi;
                            pend_lo <= div_zero ? lo_q : res_lo;
                            cnt_q   <= is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else if (op == MD_MTHI) begin
                            hi_q <= src_a;
                        end else begin
                            lo_q <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        hi_q  <= pend_hi;
                        lo_q  <= pend_lo;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with a queue of expected {HI,LO} commits.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: the bench waits on busy with a bounded cycle budget.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    logic [63:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one op for exactly one rising edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
    endtask

    // Count busy cycles from the current falling edge until busy drops (bounded).
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; op = MD_NONE; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if ({hi_out, lo_out} !== 64'd0) begin
            errors++; $display("FAIL reset_hilo got=%h_%h want=0_0", hi_out, lo_out);
        end
    endtask

    task automatic test_mult;
        int cyc;
        logic [63:0] e;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
        issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL mult_cycles got=%0d want=5", cyc); end
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL mult_result got=%h_%h want=%h", hi_out, lo_out, e); end

        exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
        issue(MD_MULTU, 32'hFFFFFFFF, 32'd2);
        wait_idle(cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL multu_cycles got=%0d want=5", cyc); end
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL multu_result got=%h_%h want=%h", hi_out, lo_out, e); end
    endtask

    task automatic test_div;
        int cyc;
        logic [63:0] e;
        logic [2:0]  ops [3]  = '{MD_DIV, MD_DIVU, MD_DIV};
        logic [31:0] as  [3]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] bs  [3]  = '{32'd2, 32'd2, 32'hFFFFFFFF};
        logic [63:0] es  [3]  = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd1, 32'd3}, {32'd0, 32'h80000000}};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(es[i]);
            issue(ops[i], as[i], bs[i]);
            wait_idle(cyc);
            checks++;
            if (cyc !== 10) begin errors++; $display("FAIL div%0d_cycles got=%0d want=10", i, cyc); end
            e = exp_q.pop_front();
            checks++;
            if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL div%0d_result got=%h_%h want=%h", i, hi_out, lo_out, e); end
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        logic [63:0] e;
        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        exp_q.push_back({32'h11, 32'h22});
        issue(MD_DIVU, 32'd5, 32'd0);
        wait_idle(cyc);
        checks++;
        if (cyc !== 10) begin errors++; $display("FAIL divzero_cycles got=%0d want=10", cyc); end
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL divzero_result got=%h_%h want=%h", hi_out, lo_out, e); end
    endtask

    task automatic test_ignored_start;
        int cyc;
        logic [63:0] e;
        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
        issue(MD_MULT, 32'hFFFFFFFF, 32'd2);
        // Second cycle of RUN: an MTHI request and new operands must both be ignored.
        start = 1'b1; op = MD_MTHI; src_a = 32'hAAAA; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        wait_idle(cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("FAIL ignored_cycles got=%0d want=4", cyc); end
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL ignored_result got=%h_%h want=%h", hi_out, lo_out, e); end

        // start presented at the commit edge itself is also dropped.
        exp_q.push_back({32'd0, 32'd15});
        issue(MD_MULTU, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL commit_edge_busy got=%b want=1", busy); end
        start = 1'b1; op = MD_MTLO; src_a = 32'h55;
        @(negedge clk);
        start = 1'b0; op = MD_NONE;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL commit_edge_fall got=%b want=0", busy); end
        e = exp_q.pop_front();
        checks++;
        if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL commit_edge_result got=%h_%h want=%h", hi_out, lo_out, e); end
    endtask

    task automatic test_mthi;
        issue(MD_MTHI, 32'h12345678, 32'd0);
        checks++;
        if (hi_out !== 32'h12345678) begin errors++; $display("FAIL mthi_value got=%h want=12345678", hi_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b want=0", busy); end
        issue(MD_MTLO, 32'hCAFEF00D, 32'd0);
        checks++;
        if ({hi_out, lo_out} !== {32'h12345678, 32'hCAFEF00D}) begin
            errors++; $display("FAIL mtlo_value got=%h_%h want=12345678_cafef00d", hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [63:0] e;
        logic [31:0] a;
        logic [31:0] b;
        logic        is_div;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            is_div = i[0];
            a = $urandom;
            b = $urandom_range(1, 32'h0000FFFF);
            if (is_div) exp_q.push_back({a % b, a / b});
            else        exp_q.push_back({32'd0, a} * {32'd0, b});
            start = 1'b1; op = is_div ? MD_DIVU : MD_MULTU; src_a = a; src_b = b;
            @(negedge clk);
            start = 1'b0; op = MD_NONE;
            wait_idle(cyc);
            checks++;
            if (cyc !== (is_div ? 10 : 5)) begin errors++; $display("FAIL b2b%0d_cycles got=%0d", i, cyc); end
            e = exp_q.pop_front();
            checks++;
            if ({hi_out, lo_out} !== e) begin errors++; $display("FAIL b2b%0d_result got=%h_%h want=%h", i, hi_out, lo_out, e); end
        end
    endtask

    task automatic test_reset_mid;
        logic bad;
        issue(MD_MTHI, 32'h77, 32'd0);
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, hi_out, lo_out} !== 65'd0) begin
            errors++; $display("FAIL reset_mid got busy=%b hilo=%h_%h want 0", busy, hi_out, lo_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL reset_no_late_commit busy=%b hilo=%h_%h want 0", busy, hi_out, lo_out);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_ignored_start();
        test_mthi();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
